// File: rtl/ult_min_tracker.sv
// Streaming per-frame minimum tracker: reports min sample, first index of min and an overflow flag.
// Define ULT_MIN_TRACKER_MAX_EN to also build a parallel maximum tracker (O_MAX / O_MAX_IDX).
module ult_min_tracker #(
   parameter int WIDTH = 2,
   parameter int IDXW  = 4
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic             I_VALID,
   output logic             I_READY,
   input  logic [WIDTH-1:0] I,
   input  logic             I_LAST,
   output logic             O_VALID,
   input  logic             O_READY,
   output logic [WIDTH-1:0] O,
   output logic [IDXW-1:0]  O_IDX,
   output logic             O_OVF,
   output logic [WIDTH-1:0] O_MAX,
   output logic [IDXW-1:0]  O_MAX_IDX
);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   localparam logic [IDXW-1:0] CNT_MAX = '1;

   state_t           state;
   state_t           state_nxt;
   logic             take;
   logic [WIDTH-1:0] acc_min;
   logic [IDXW-1:0]  acc_min_idx;
   logic [IDXW-1:0]  count;
   logic             acc_ovf;
   logic [WIDTH-1:0] min_nxt;
   logic [IDXW-1:0]  min_idx_nxt;
   logic [IDXW-1:0]  count_nxt;
   logic             ovf_nxt;

   function automatic logic ult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      return a < b;
   endfunction

   assign take = I_VALID & I_READY;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (take) state_nxt = I_LAST ? HOLD : ACCUM;
         ACCUM:   if (take && I_LAST) state_nxt = HOLD;
         HOLD:    if (O_READY) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      I_READY = (state != HOLD);
      O_VALID = (state == HOLD);
   end

   // Once the count saturates, later minima report the saturated index.
   always_comb begin
      min_nxt     = acc_min;
      min_idx_nxt = acc_min_idx;
      count_nxt   = count;
      ovf_nxt     = acc_ovf;
      if (state == IDLE) begin
         min_nxt     = I;
         min_idx_nxt = '0;
         count_nxt   = IDXW'(1);
         ovf_nxt     = 1'b0;
      end else begin
         if (ult(I, acc_min)) begin
            min_nxt     = I;
            min_idx_nxt = count;
         end
         if (count == CNT_MAX) begin
            ovf_nxt = 1'b1;
         end else begin
            count_nxt = count + 1'b1;
         end
      end
   end

   // Result registers load only on the last transfer so they hold the previous frame otherwise.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         acc_min     <= '0;
         acc_min_idx <= '0;
         count       <= '0;
         acc_ovf     <= 1'b0;
         O           <= '0;
         O_IDX       <= '0;
         O_OVF       <= 1'b0;
      end else if (take) begin
         acc_min     <= min_nxt;
         acc_min_idx <= min_idx_nxt;
         count       <= count_nxt;
         acc_ovf     <= ovf_nxt;
         if (I_LAST) begin
            O     <= min_nxt;
            O_IDX <= min_idx_nxt;
            O_OVF <= ovf_nxt;
         end
      end
   end

`ifdef ULT_MIN_TRACKER_MAX_EN
   logic [WIDTH-1:0] acc_max;
   logic [IDXW-1:0]  acc_max_idx;
   logic [WIDTH-1:0] max_nxt;
   logic [IDXW-1:0]  max_idx_nxt;

   always_comb begin
      max_nxt     = acc_max;
      max_idx_nxt = acc_max_idx;
      if (state == IDLE) begin
         max_nxt     = I;
         max_idx_nxt = '0;
      end else if (ult(acc_max, I)) begin
         max_nxt     = I;
         max_idx_nxt = count;
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         acc_max     <= '0;
         acc_max_idx <= '0;
         O_MAX       <= '0;
         O_MAX_IDX   <= '0;
      end else if (take) begin
         acc_max     <= max_nxt;
         acc_max_idx <= max_idx_nxt;
         if (I_LAST) begin
            O_MAX     <= max_nxt;
            O_MAX_IDX <= max_idx_nxt;
         end
      end
   end
`else
   assign O_MAX     = '0;
   assign O_MAX_IDX = '0;
`endif

endmodule

// File: tb/tb_ult_min_tracker.sv
// Scoreboard bench for ult_min_tracker: frames are modelled when driven and compared on result handshake.
// Honours ULT_MIN_TRACKER_MAX_EN for the max-tracker expectations.
module tb_ult_min_tracker;

   localparam int WIDTH = 2;
   localparam int IDXW  = 4;

   typedef struct packed {
      logic [WIDTH-1:0] mn;
      logic [IDXW-1:0]  mn_idx;
      logic             ovf;
      logic [WIDTH-1:0] mx;
      logic [IDXW-1:0]  mx_idx;
   } exp_t;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic             i_valid = 1'b0;
   logic             i_ready;
   logic [WIDTH-1:0] i_data = '0;
   logic             i_last = 1'b0;
   logic             o_valid;
   logic             o_ready = 1'b1;
   logic [WIDTH-1:0] o_data;
   logic [IDXW-1:0]  o_idx;
   logic             o_ovf;
   logic [WIDTH-1:0] o_max;
   logic [IDXW-1:0]  o_max_idx;

   exp_t             exp_q[$];
   exp_t             mon_e;
   logic [WIDTH-1:0] frame[$];
   int               checks = 0;
   int               errors = 0;

   ult_min_tracker #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
      .CLK(clk), .RESETN(resetn),
      .I_VALID(i_valid), .I_READY(i_ready), .I(i_data), .I_LAST(i_last),
      .O_VALID(o_valid), .O_READY(o_ready), .O(o_data), .O_IDX(o_idx), .O_OVF(o_ovf),
      .O_MAX(o_max), .O_MAX_IDX(o_max_idx)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: strict compares keep the earliest index; index saturates at 2^IDXW-1.
   function automatic exp_t modelFrame();
      exp_t e;
      int   n = frame.size();
      int   pos;
      e.mn = frame[0];
      e.mn_idx = '0;
      e.mx = frame[0];
      e.mx_idx = '0;
      for (int k = 1; k < n; k++) begin
         pos = (k > (1 << IDXW) - 1) ? (1 << IDXW) - 1 : k;
         if (frame[k] < e.mn) begin
            e.mn = frame[k];
            e.mn_idx = IDXW'(pos);
         end
         if (frame[k] > e.mx) begin
            e.mx = frame[k];
            e.mx_idx = IDXW'(pos);
         end
      end
      e.ovf = (n >= (1 << IDXW));
`ifndef ULT_MIN_TRACKER_MAX_EN
      e.mx = '0;
      e.mx_idx = '0;
`endif
      return e;
   endfunction

   task automatic applyStimulus(input bit has_last, input bit with_gaps);
      int n = frame.size();
      int waits;
      if (has_last) exp_q.push_back(modelFrame());
      for (int k = 0; k < n; k++) begin
         if (with_gaps) begin
            i_valid = 1'b0;
            @(posedge clk); #1;
         end
         i_valid = 1'b1;
         i_data  = frame[k];
         i_last  = has_last && (k == n - 1);
         waits   = 0;
         while (!i_ready && waits < 50) begin
            @(posedge clk); #1;
            waits++;
         end
         if (!i_ready) begin
            checkOutput("ready_timeout", 32'(i_ready), 1);
            break;
         end
         @(posedge clk); #1;
      end
      i_valid = 1'b0;
      i_last  = 1'b0;
      if (has_last) checkOutput("latency_o_valid", 32'(o_valid), 1);
   endtask

   always @(negedge clk) begin
      if (resetn && o_valid && o_ready) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_result", 32'(o_valid), 0);
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("o_min", 32'(o_data), 32'(mon_e.mn));
            checkOutput("o_idx", 32'(o_idx), 32'(mon_e.mn_idx));
            checkOutput("o_ovf", 32'(o_ovf), 32'(mon_e.ovf));
            checkOutput("o_max", 32'(o_max), 32'(mon_e.mx));
            checkOutput("o_max_idx", 32'(o_max_idx), 32'(mon_e.mx_idx));
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #12;
      checkOutput("rst_i_ready", 32'(i_ready), 1);
      checkOutput("rst_o_valid", 32'(o_valid), 0);
      checkOutput("rst_o", 32'(o_data), 0);
      checkOutput("rst_o_idx", 32'(o_idx), 0);
      checkOutput("rst_o_ovf", 32'(o_ovf), 0);
      checkOutput("rst_o_max", 32'(o_max), 0);
      checkOutput("rst_o_max_idx", 32'(o_max_idx), 0);
      #1 resetn = 1'b1;
      @(posedge clk); #1;

      frame = {2'd3, 2'd1, 2'd2, 2'd0, 2'd2};
      applyStimulus(1'b1, 1'b0);
      @(posedge clk); #1;
      checkOutput("pulse_o_valid", 32'(o_valid), 0);
      checkOutput("pulse_i_ready", 32'(i_ready), 1);

      frame = {2'd2, 2'd1, 2'd1, 2'd3};
      applyStimulus(1'b1, 1'b0);
      @(posedge clk); #1;

      o_ready = 1'b0;
      frame = {2'd2};
      applyStimulus(1'b1, 1'b0);
      i_valid = 1'b1;
      i_data  = 2'd0;
      for (int c = 0; c < 5; c++) begin
         checkOutput("bp_o_valid", 32'(o_valid), 1);
         checkOutput("bp_i_ready", 32'(i_ready), 0);
         checkOutput("bp_o", 32'(o_data), 2);
         checkOutput("bp_o_idx", 32'(o_idx), 0);
         @(posedge clk); #1;
      end
      i_valid = 1'b0;
      o_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp_release_o_valid", 32'(o_valid), 0);
      checkOutput("bp_release_i_ready", 32'(i_ready), 1);

      frame.delete();
      for (int k = 0; k < 18; k++) frame.push_back((k == 17) ? 2'd0 : 2'd3);
      applyStimulus(1'b1, 1'b0);
      @(posedge clk); #1;

      frame = {2'd3, 2'd2};
      applyStimulus(1'b0, 1'b1);
      #3 resetn = 1'b0;
      #1;
      checkOutput("midrst_o_valid", 32'(o_valid), 0);
      checkOutput("midrst_i_ready", 32'(i_ready), 1);
      checkOutput("midrst_o", 32'(o_data), 0);
      #2 resetn = 1'b1;
      @(posedge clk); #1;
      frame = {2'd1, 2'd3};
      applyStimulus(1'b1, 1'b1);
      @(posedge clk); #1;

      for (int f = 0; f < 4; f++) begin
         frame.delete();
         for (int k = 0; k < int'($urandom_range(1, 9)); k++) frame.push_back(WIDTH'($urandom_range(0, 3)));
         applyStimulus(1'b1, f[0]);
         @(posedge clk); #1;
      end

      repeat (3) @(posedge clk);
      #1;
      checkOutput("scoreboard_drained", 32'(exp_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
